// File: rtl/bist_pkg.sv
// Shared definitions for the logic-BIST sequencer: the state encoding and
// the default signature width and golden-signature value.
package bist_pkg;

   // 3-bit binary state encoding
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_INIT    = 3'd1;
   localparam logic [2:0] ST_RUN     = 3'd2;
   localparam logic [2:0] ST_FLUSH   = 3'd3;
   localparam logic [2:0] ST_COMPARE = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      INIT    = ST_INIT,
      RUN     = ST_RUN,
      FLUSH   = ST_FLUSH,
      COMPARE = ST_COMPARE,
      DONE    = ST_DONE
   } state_t;

   // Default MISR width and fault-free signature
   localparam int                   SIG_W_DEF      = 7;
   localparam logic [SIG_W_DEF-1:0] GOLDEN_SIG_DEF = 7'h00;

endpackage

// File: rtl/bist_sequencer_if.sv
// Handshake and control bundle between the BIST sequencer and its
// surroundings (start request, MISR signature, TPG/MISR/mux controls, result).
interface bist_sequencer_if
   import bist_pkg::*;
#(
   parameter int SIG_W = SIG_W_DEF
);
   logic             bist_start;
   logic [SIG_W-1:0] misr_sig;
   logic             test_mode;
   logic             tpg_init;
   logic             tpg_en;
   logic             misr_init;
   logic             misr_en;
   logic             bist_end;
   logic             pass_nfail;

   // Sequencer side: drives the controls and the result
   modport master (
      input  bist_start, misr_sig,
      output test_mode, tpg_init, tpg_en, misr_init, misr_en, bist_end, pass_nfail
   );

   // Environment side: requests a session and supplies the signature
   modport slave (
      output bist_start, misr_sig,
      input  test_mode, tpg_init, tpg_en, misr_init, misr_en, bist_end, pass_nfail
   );
endinterface

// File: rtl/bist_cycle_counter.sv
// Loadable down-counter that times the RUN and FLUSH phases of a session.
// Load has priority over decrement; zero flags a count of 0.
module bist_cycle_counter #(
   parameter int CNT_W = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);
   logic [CNT_W-1:0] cnt;

   // Count register: reload on phase entry, otherwise step down when enabled
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      if (reset)     cnt <= '0;
      else if (load) cnt <= load_val;
      else if (dec)  cnt <= cnt - CNT_W'(1);
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/bist_sequencer.sv
// Logic-BIST session sequencer: arms the TPG and MISR, applies N_PATTERNS
// patterns in test mode, flushes the CUT pipeline into the MISR, then
// compares the signature against GOLDEN_SIG and reports bist_end/pass_nfail.
module bist_sequencer
   import bist_pkg::*;
#(
   parameter int               N_PATTERNS   = 1000,
   parameter int               FLUSH_CYCLES = 2,
   parameter int               CNT_W        = 10,
   parameter int               SIG_W        = SIG_W_DEF,
   parameter logic [SIG_W-1:0] GOLDEN_SIG   = GOLDEN_SIG_DEF
) (
   input  logic             clock,
   input  logic             reset,
   bist_sequencer_if.master bus
);
   // Reload values; the flush value is unused when FLUSH_CYCLES is 0
   localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(N_PATTERNS - 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;

   state_t           state, state_next;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_load_val;
   logic             pass_q;

   bist_cycle_counter #(.CNT_W(CNT_W)) u_counter (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state and counter control; a dropped bist_start aborts any active phase
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_next   = state;
      cnt_load     = 1'b0;
      cnt_load_val = RUN_LOAD;
      cnt_dec      = 1'b0;
      unique case (state)
         IDLE: if (bus.bist_start) state_next = INIT;
         INIT: begin
            if (!bus.bist_start) state_next = IDLE;
            else begin
               state_next = RUN;
               cnt_load   = 1'b1;
            end
         end
         RUN: begin
            if (!bus.bist_start) state_next = IDLE;
            else if (cnt_zero) begin
               if (FLUSH_CYCLES > 0) begin
                  state_next   = FLUSH;
                  cnt_load     = 1'b1;
                  cnt_load_val = FLUSH_LOAD;
               end else begin
                  state_next = COMPARE;
               end
            end else cnt_dec = 1'b1;
         end
         FLUSH: begin
            if (!bus.bist_start) state_next = IDLE;
            else if (cnt_zero)   state_next = COMPARE;
            else                 cnt_dec    = 1'b1;
         end
         COMPARE: state_next = bus.bist_start ? DONE : IDLE;
         DONE:    if (!bus.bist_start) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Result register: captured on COMPARE->DONE, held in DONE, cleared everywhere else
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                   pass_q <= 1'b0;
      else if (state_next != DONE) pass_q <= 1'b0;
      else if (state == COMPARE)   pass_q <= (bus.misr_sig == GOLDEN_SIG);
   end

   // Moore output decode from the state register only
   always_comb begin
      bus.test_mode = 1'b0;
      bus.tpg_init  = 1'b0;
      bus.tpg_en    = 1'b0;
      bus.misr_init = 1'b0;
      bus.misr_en   = 1'b0;
      bus.bist_end  = 1'b0;
      unique case (state)
         INIT: begin
            bus.test_mode = 1'b1;
            bus.tpg_init  = 1'b1;
            bus.misr_init = 1'b1;
         end
         RUN: begin
            bus.test_mode = 1'b1;
            bus.tpg_en    = 1'b1;
            bus.misr_en   = 1'b1;
         end
         FLUSH: begin
            bus.test_mode = 1'b1;
            bus.misr_en   = 1'b1;
         end
         COMPARE: bus.test_mode = 1'b1;
         DONE:    bus.bist_end  = 1'b1;
         default: ;
      endcase
   end

   assign bus.pass_nfail = pass_q;
endmodule
